// File: rtl/d_drain_arbiter.sv
// Drain stage for the D0/D1 destination FIFOs: round-robin pops, two-entry
// in-order output buffer with valid/ready, per-destination delivery counters.
module d_drain_arbiter #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              empty_fifo_D0,
    input  logic              empty_fifo_D1,
    input  logic [DATA_W-1:0] data_out_D0,
    input  logic [DATA_W-1:0] data_out_D1,
    input  logic              error_D0,
    input  logic              error_D1,
    input  logic              out_ready,
    output logic              D0_pop,
    output logic              D1_pop,
    output logic [DATA_W-1:0] data_out,
    output logic              dest_out,
    output logic              valid_out,
    output logic [CNT_W-1:0]  count_D0,
    output logic [CNT_W-1:0]  count_D1,
    output logic [1:0]        state_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_STALL  = 2'b10
    } state_t;

    logic [1:0]        occ_q, occ_d;
    logic              inflight_q, inflight_d;
    logic              infl_dest_q, infl_dest_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic              dest0_q, dest0_d, dest1_q, dest1_d;
    logic [CNT_W-1:0]  count_d0_q, count_d0_d, count_d1_q, count_d1_d;
    state_t            state_q, state_d;

    logic              valid;
    logic              consume;
    logic [2:0]        level;
    logic              can_issue;
    logic              elig0, elig1;
    logic              pop0, pop1;
    logic [1:0]        tail;
    logic [DATA_W-1:0] cap_data;

    always_comb begin
        valid     = (occ_q != 2'd0);
        consume   = valid & out_ready;
        // Words held or about to land, net of the one leaving this edge.
        level     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, consume};
        can_issue = (level < 3'd2);
        elig0     = !empty_fifo_D0 && !error_D0;
        elig1     = !empty_fifo_D1 && !error_D1;
        pop0      = !reset && can_issue && elig0 && (!elig1 || last_q);
        pop1      = !reset && can_issue && elig1 && (!elig0 || !last_q);

        data0_d    = data0_q;
        dest0_d    = dest0_q;
        data1_d    = data1_q;
        dest1_d    = dest1_q;
        count_d0_d = count_d0_q;
        count_d1_d = count_d1_q;

        if (consume) begin
            data0_d = data1_q;
            dest0_d = dest1_q;
            if (dest0_q) count_d1_d = count_d1_q + 1'b1;
            else         count_d0_d = count_d0_q + 1'b1;
        end

        // Tail slot is computed after the head shift so capture and consume can share an edge.
        tail     = occ_q - {1'b0, consume};
        cap_data = infl_dest_q ? data_out_D1 : data_out_D0;
        if (inflight_q) begin
            if (tail == 2'd0) begin
                data0_d = cap_data;
                dest0_d = infl_dest_q;
            end else begin
                data1_d = cap_data;
                dest1_d = infl_dest_q;
            end
        end

        occ_d       = level[1:0];
        inflight_d  = pop0 | pop1;
        infl_dest_d = pop1;
        last_d      = (pop0 | pop1) ? pop1 : last_q;

        if (occ_d == 2'd0 && !(pop0 | pop1) && empty_fifo_D0 && empty_fifo_D1)
            state_d = ST_IDLE;
        else if (occ_d == 2'd2 && !out_ready)
            state_d = ST_STALL;
        else
            state_d = ST_ACTIVE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q       <= 2'd0;
            inflight_q  <= 1'b0;
            infl_dest_q <= 1'b0;
            last_q      <= 1'b1;
            data0_q     <= '0;
            data1_q     <= '0;
            dest0_q     <= 1'b0;
            dest1_q     <= 1'b0;
            count_d0_q  <= '0;
            count_d1_q  <= '0;
            state_q     <= ST_IDLE;
        end else begin
            occ_q       <= occ_d;
            inflight_q  <= inflight_d;
            infl_dest_q <= infl_dest_d;
            last_q      <= last_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            dest0_q     <= dest0_d;
            dest1_q     <= dest1_d;
            count_d0_q  <= count_d0_d;
            count_d1_q  <= count_d1_d;
            state_q     <= state_d;
        end
    end

    assign D0_pop    = pop0;
    assign D1_pop    = pop1;
    assign data_out  = data0_q;
    assign dest_out  = dest0_q;
    assign valid_out = valid;
    assign count_D0  = count_d0_q;
    assign count_D1  = count_d1_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_d_drain_arbiter.sv
// Directed bench for d_drain_arbiter: behavioural D0/D1 FIFOs, a per-cycle
// vector table for round-robin, and hand-written multi-cycle sequences.
module tb_d_drain_arbiter;
    localparam int DATA_W = 6;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              e0, e1, err0, err1, rdy;
    logic [DATA_W-1:0] rd0, rd1;
    logic              D0_pop, D1_pop, dest_out, valid_out;
    logic [DATA_W-1:0] data_out;
    logic [CNT_W-1:0]  count_D0, count_D1;
    logic [1:0]        state_out;

    always #5 clk = ~clk;

    d_drain_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .empty_fifo_D0(e0), .empty_fifo_D1(e1),
        .data_out_D0(rd0), .data_out_D1(rd1),
        .error_D0(err0), .error_D1(err1),
        .out_ready(rdy),
        .D0_pop(D0_pop), .D1_pop(D1_pop),
        .data_out(data_out), .dest_out(dest_out), .valid_out(valid_out),
        .count_D0(count_D0), .count_D1(count_D1), .state_out(state_out)
    );

    typedef struct packed {
        logic       rdy;
        logic       p0;
        logic       p1;
        logic       v;
        logic [5:0] d;
        logic       dst;
        logic [1:0] st;
    } vec_t;

    vec_t tbl [9];

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] q0 [$];
    logic [DATA_W-1:0] q1 [$];
    logic [DATA_W:0]   expq [$];
    logic sb_en;
    logic p0_s, p1_s;

    function automatic vec_t mk(input logic r, input logic a, input logic b, input logic v,
                                input logic [5:0] d, input logic dst, input logic [1:0] st);
        vec_t x;
        x.rdy = r; x.p0 = a; x.p1 = b; x.v = v; x.d = d; x.dst = dst; x.st = st;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic at_neg();
        logic [DATA_W:0] w;
        @(negedge clk);
        if (sb_en && valid_out && rdy) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual %0h required none at %0t",
                         {dest_out, data_out}, $time);
            end else begin
                w = expq.pop_front();
                chk("sb_word", {25'd0, dest_out, data_out}, {25'd0, w});
            end
        end
    endtask

    task automatic edge_adv();
        p0_s = D0_pop;
        p1_s = D1_pop;
        @(posedge clk);
        #1;
        if (p0_s && q0.size() > 0) rd0 = q0.pop_front();
        if (p1_s && q1.size() > 0) rd1 = q1.pop_front();
        e0 = (q0.size() == 0);
        e1 = (q1.size() == 0);
    endtask

    task automatic load(input logic dst, input logic [DATA_W-1:0] d, input logic track);
        if (dst) begin q1.push_back(d); e1 = 1'b0; end
        else     begin q0.push_back(d); e0 = 1'b0; end
        if (track) expq.push_back({dst, d});
    endtask

    task automatic do_reset();
        sb_en = 1'b0;
        reset = 1'b1;
        repeat (2) begin
            at_neg();
            edge_adv();
        end
        reset = 1'b0;
        expq.delete();
    endtask

    task automatic drain(input int maxc);
        logic done;
        done = 1'b0;
        for (int i = 0; i < maxc && !done; i++) begin
            at_neg();
            if (expq.size() == 0 && !valid_out && !D0_pop && !D1_pop && state_out == 2'b00)
                done = 1'b1;
            edge_adv();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual %0d words left required 0", expq.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rdy = 1'b0; err0 = 1'b0; err1 = 1'b0;
        e0 = 1'b1; e1 = 1'b1; rd0 = '0; rd1 = '0; sb_en = 1'b0;
        p0_s = 1'b0; p1_s = 1'b0;

        tbl[0] = mk(1, 1, 0, 0, 6'd0,  0, 2'b00);
        tbl[1] = mk(1, 0, 1, 0, 6'd0,  0, 2'b01);
        tbl[2] = mk(1, 1, 0, 1, 6'd1,  0, 2'b01);
        tbl[3] = mk(1, 0, 1, 1, 6'd11, 1, 2'b01);
        tbl[4] = mk(1, 1, 0, 1, 6'd2,  0, 2'b01);
        tbl[5] = mk(1, 0, 1, 1, 6'd12, 1, 2'b01);
        tbl[6] = mk(1, 0, 0, 1, 6'd3,  0, 2'b01);
        tbl[7] = mk(1, 0, 0, 1, 6'd13, 1, 2'b01);
        tbl[8] = mk(1, 0, 0, 0, 6'd0,  0, 2'b00);

        do_reset();

        // Reset state
        at_neg();
        chk("rst_pop0", {31'd0, D0_pop}, 32'd0);
        chk("rst_pop1", {31'd0, D1_pop}, 32'd0);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_data", {26'd0, data_out}, 32'd0);
        chk("rst_dest", {31'd0, dest_out}, 32'd0);
        chk("rst_cnt0", {24'd0, count_D0}, 32'd0);
        chk("rst_cnt1", {24'd0, count_D1}, 32'd0);
        chk("rst_state", {30'd0, state_out}, 32'd0);
        edge_adv();

        // Single word
        rdy = 1'b1;
        load(1'b0, 6'h15, 1'b0);
        at_neg(); chk("sw_pop_c0", {31'd0, D0_pop}, 32'd1); edge_adv();
        at_neg(); chk("sw_pop_c1", {31'd0, D0_pop}, 32'd0);
                  chk("sw_valid_c1", {31'd0, valid_out}, 32'd0); edge_adv();
        at_neg(); chk("sw_valid_c2", {31'd0, valid_out}, 32'd1);
                  chk("sw_data_c2", {26'd0, data_out}, 32'h15);
                  chk("sw_dest_c2", {31'd0, dest_out}, 32'd0);
                  chk("sw_state_c2", {30'd0, state_out}, 32'd1); edge_adv();
        at_neg(); chk("sw_cnt0_c3", {24'd0, count_D0}, 32'd1);
                  chk("sw_state_c3", {30'd0, state_out}, 32'd0);
                  chk("sw_valid_c3", {31'd0, valid_out}, 32'd0); edge_adv();

        // Round-robin, table driven
        do_reset();
        load(1'b0, 6'd1, 1'b0); load(1'b0, 6'd2, 1'b0); load(1'b0, 6'd3, 1'b0);
        load(1'b1, 6'd11, 1'b0); load(1'b1, 6'd12, 1'b0); load(1'b1, 6'd13, 1'b0);
        for (int i = 0; i < 9; i++) begin
            rdy = tbl[i].rdy;
            at_neg();
            chk($sformatf("rr%0d_pop0", i), {31'd0, D0_pop}, {31'd0, tbl[i].p0});
            chk($sformatf("rr%0d_pop1", i), {31'd0, D1_pop}, {31'd0, tbl[i].p1});
            chk($sformatf("rr%0d_valid", i), {31'd0, valid_out}, {31'd0, tbl[i].v});
            chk($sformatf("rr%0d_state", i), {30'd0, state_out}, {30'd0, tbl[i].st});
            if (tbl[i].v) begin
                chk($sformatf("rr%0d_data", i), {26'd0, data_out}, {26'd0, tbl[i].d});
                chk($sformatf("rr%0d_dest", i), {31'd0, dest_out}, {31'd0, tbl[i].dst});
            end
            edge_adv();
        end
        chk("rr_cnt0", {24'd0, count_D0}, 32'd3);
        chk("rr_cnt1", {24'd0, count_D1}, 32'd3);

        // Backpressure on a D1 stream
        do_reset();
        sb_en = 1'b1;
        rdy = 1'b1;
        for (int i = 0; i < 5; i++) load(1'b1, 6'(21 + i), 1'b1);
        repeat (3) begin at_neg(); edge_adv(); end
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk($sformatf("bp%0d_pop0", i), {31'd0, D0_pop}, 32'd0);
            chk($sformatf("bp%0d_pop1", i), {31'd0, D1_pop}, 32'd0);
            if (i == 3) chk("bp_state_stall", {30'd0, state_out}, 32'd2);
            edge_adv();
        end
        rdy = 1'b1;
        at_neg(); chk("bp_release_pop1", {31'd0, D1_pop}, 32'd1); edge_adv();
        drain(50);
        chk("bp_cnt1", {24'd0, count_D1}, 32'd5);

        // Error masking on D1
        do_reset();
        sb_en = 1'b1;
        rdy = 1'b1;
        err1 = 1'b1;
        load(1'b0, 6'd31, 1'b0); load(1'b0, 6'd32, 1'b0); load(1'b0, 6'd33, 1'b0);
        load(1'b1, 6'd41, 1'b0); load(1'b1, 6'd42, 1'b0); load(1'b1, 6'd43, 1'b0);
        expq.push_back({1'b0, 6'd31}); expq.push_back({1'b0, 6'd32});
        expq.push_back({1'b1, 6'd41}); expq.push_back({1'b0, 6'd33});
        expq.push_back({1'b1, 6'd42}); expq.push_back({1'b1, 6'd43});
        for (int i = 0; i < 2; i++) begin
            at_neg();
            chk($sformatf("err%0d_pop0", i), {31'd0, D0_pop}, 32'd1);
            chk($sformatf("err%0d_pop1", i), {31'd0, D1_pop}, 32'd0);
            edge_adv();
        end
        err1 = 1'b0;
        at_neg(); chk("err_clr_pop1", {31'd0, D1_pop}, 32'd1);
                  chk("err_clr_pop0", {31'd0, D0_pop}, 32'd0); edge_adv();
        at_neg(); chk("err_alt_pop0", {31'd0, D0_pop}, 32'd1); edge_adv();
        at_neg(); chk("err_alt_pop1", {31'd0, D1_pop}, 32'd1); edge_adv();
        drain(50);

        // Counter wrap
        do_reset();
        sb_en = 1'b1;
        rdy = 1'b1;
        load(1'b1, 6'h07, 1'b1);
        drain(20);
        for (int i = 0; i < 256; i++) load(1'b0, 6'(i), 1'b1);
        drain(400);
        chk("wrap_cnt0", {24'd0, count_D0}, 32'd0);
        chk("wrap_cnt1", {24'd0, count_D1}, 32'd1);

        // Reset in the cycle after a pop
        do_reset();
        sb_en = 1'b1;
        rdy = 1'b1;
        load(1'b1, 6'h3C, 1'b1);
        drain(20);
        chk("mr_pre_cnt1", {24'd0, count_D1}, 32'd1);
        load(1'b0, 6'h2A, 1'b0);
        at_neg(); chk("mr_pop0", {31'd0, D0_pop}, 32'd1); edge_adv();
        reset = 1'b1;
        at_neg(); chk("mr_rst_pop0", {31'd0, D0_pop}, 32'd0); edge_adv();
        reset = 1'b0;
        at_neg();
        chk("mr_valid", {31'd0, valid_out}, 32'd0);
        chk("mr_cnt0", {24'd0, count_D0}, 32'd0);
        chk("mr_cnt1", {24'd0, count_D1}, 32'd0);
        chk("mr_state", {30'd0, state_out}, 32'd0);
        edge_adv();
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk($sformatf("mr_quiet%0d", i), {31'd0, valid_out}, 32'd0);
            edge_adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
